// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared state type and limits for the divider shift control
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_e;

  localparam int SHIFT_POS_W    = 3;
  localparam int MAX_STEP_LIMIT = 7;

endpackage

// File: rtl/right_shift_sequencer.sv
// rtl/right_shift_sequencer.sv - splits a right shift of N into a load plus capped shift steps
module right_shift_sequencer
  import divider_pkg::*;
#(
  parameter int WIDTH    = 17,
  parameter int AMT_W    = 5,
  parameter int MAX_STEP = 7
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   start,
  input  logic [AMT_W-1:0]       amount,
  input  logic                   abort,
  output logic                   sh_load,
  output logic                   sh_enable,
  output logic [SHIFT_POS_W-1:0] sh_shift_pos,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [AMT_W-1:0]       step_count
);

  if (MAX_STEP < 1 || MAX_STEP > MAX_STEP_LIMIT) begin : g_bad_max_step
    $error("MAX_STEP out of range");
  end
  if ((1 << AMT_W) <= WIDTH) begin : g_bad_amt_w
    $error("AMT_W too narrow for WIDTH");
  end

  localparam logic [AMT_W-1:0] WIDTH_A    = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] MAX_STEP_A = AMT_W'(MAX_STEP);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] steps_q, steps_d;
  logic             aborted_q, aborted_d;
  logic [AMT_W-1:0] step;
  logic [AMT_W-1:0] rem_after;

  assign step      = (rem_q < MAX_STEP_A) ? rem_q : MAX_STEP_A;
  assign rem_after = rem_q - step;

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      steps_q   <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      steps_q   <= steps_d;
      aborted_q <= aborted_d;
    end
  end

  // step_count advances as each enable cycle is entered, so it already counts the current one
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    steps_d   = steps_q;
    aborted_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = (amount > WIDTH_A) ? WIDTH_A : amount;
          steps_d = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (rem_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
          steps_d = steps_q + 1'b1;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else begin
          rem_d = rem_after;
          if (rem_after == '0) begin
            state_d = DONE;
          end else begin
            steps_d = steps_q + 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sh_load      = (state_q == LOAD);
  assign sh_enable    = (state_q == SHIFT);
  assign sh_shift_pos = sh_enable ? step[SHIFT_POS_W-1:0] : '0;
  assign busy         = (state_q == LOAD) || (state_q == SHIFT);
  assign done         = (state_q == DONE);
  assign aborted      = aborted_q;
  assign step_count   = steps_q;

endmodule

// File: tb/tb_right_shift_sequencer.sv
// tb/tb_right_shift_sequencer.sv - scoreboard bench for right_shift_sequencer
module tb_right_shift_sequencer;

  localparam int K_LOAD = 0;
  localparam int K_EN   = 1;
  localparam int K_DONE = 2;
  localparam int K_ABT  = 3;

  typedef struct {
    int kind;
    int cyc;
    int pos;
    int sc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_b = 1'b1;
  logic       start = 1'b0;
  logic [4:0] amount = '0;
  logic       abort = 1'b0;
  logic       sh_load, sh_enable, busy, done, aborted;
  logic [2:0] sh_shift_pos;
  logic [4:0] step_count;

  ev_t         q[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  bit          mon_en = 1'b0;
  logic [16:0] shreg = '0;

  right_shift_sequencer #(.WIDTH(17), .AMT_W(5), .MAX_STEP(7)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .amount(amount), .abort(abort),
    .sh_load(sh_load), .sh_enable(sh_enable), .sh_shift_pos(sh_shift_pos),
    .busy(busy), .done(done), .aborted(aborted), .step_count(step_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 17-bit right shifter driven by the sequencer
  always @(posedge clk) begin
    if (sh_load) shreg <= 17'h1FFFF;
    else if (sh_enable) shreg <= shreg >> sh_shift_pos;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    int  kind;
    ev_t e;
    if (mon_en) begin
      if (!sh_enable) chk("pos_when_idle", int'(sh_shift_pos), 0);
      if (sh_load || sh_enable || done || aborted) begin
        kind = aborted ? K_ABT : done ? K_DONE : sh_load ? K_LOAD : K_EN;
        chk("load_enable_exclusive", int'(sh_load & sh_enable), 0);
        if (q.size() == 0) begin
          chk("unexpected_event", kind, -1);
        end else begin
          e = q.pop_front();
          chk("event_kind", kind, e.kind);
          chk("event_cycle", cyc, e.cyc);
          if (kind == K_EN) chk("shift_pos", int'(sh_shift_pos), e.pos);
          if (kind >= K_DONE) chk("step_count", int'(step_count), e.sc);
          chk("busy", int'(busy), (kind < K_DONE) ? 1 : 0);
        end
      end
    end
  end

  task automatic push(input int kind, input int c, input int pos, input int sc);
    ev_t e;
    e.kind = kind; e.cyc = c; e.pos = pos; e.sc = sc;
    q.push_back(e);
  endtask

  // Issue one request; abort_step / restart_step inject abort or a stray start during that enable cycle
  task automatic run(input int amt, input int abort_step, input int restart_step,
                     input logic [16:0] exp_sh);
    int n, k, rem, p, c, last;
    bit ab;
    n = (amt > 17) ? 17 : amt;
    c = cyc;
    push(K_LOAD, c + 1, 0, 0);
    rem = n; k = 0; ab = 1'b0;
    while (rem > 0 && !ab) begin
      k++;
      p = (rem > 7) ? 7 : rem;
      push(K_EN, c + 1 + k, p, 0);
      rem -= p;
      if (k == abort_step) ab = 1'b1;
    end
    push(ab ? K_ABT : K_DONE, c + 2 + k, 0, k);
    last = c + 4 + k;
    start = 1'b1;
    amount = 5'(amt);
    while (cyc < last) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      if (abort_step > 0 && cyc == c + 1 + abort_step) abort = 1'b1;
      if (restart_step > 0 && cyc == c + 1 + restart_step) begin
        start = 1'b1;
        amount = 5'd2;
      end
    end
    chk($sformatf("drained_amt%0d", amt), q.size(), 0);
    chk($sformatf("shifter_amt%0d", amt), int'(shreg), int'(exp_sh));
    q.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", int'({sh_load, sh_enable, sh_shift_pos, busy, done, aborted, step_count}), 0);
    mon_en = 1'b1;
    rst_b = 1'b0;
    @(posedge clk);
    #1;

    run(0,  0, 0, 17'h1FFFF);
    run(5,  0, 0, 17'h00FFF);
    run(7,  0, 0, 17'h003FF);
    run(8,  0, 0, 17'h001FF);
    run(17, 0, 0, 17'h00000);
    run(20, 0, 0, 17'h00000);
    run(17, 2, 0, 17'h00007);
    run(3,  0, 0, 17'h03FFF);
    run(17, 0, 1, 17'h00000);

    begin : mid_reset
      int c;
      c = cyc;
      push(K_LOAD, c + 1, 0, 0);
      push(K_EN, c + 2, 7, 0);
      start = 1'b1;
      amount = 5'd17;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst_b = 1'b1;
      @(posedge clk); #1;
      rst_b = 1'b0;
      chk("mid_reset_outputs", int'({sh_load, sh_enable, sh_shift_pos, busy, done, aborted, step_count}), 0);
      @(posedge clk); #1;
      chk("mid_reset_drained", q.size(), 0);
      q.delete();
    end

    run(4, 0, 0, 17'h01FFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/right_shift_sequencer.md
Name: right_shift_sequencer

Overview:
- Control sequencer for the divider's parametrized right shifter.
- Takes a request for a total right shift of N positions and breaks it into a load cycle plus shift cycles of at most MAX_STEP positions each.
- Drives the shifter's load, enable and shift_pos inputs.
- Sits between the divider FSM, which issues start/abort and waits for done, and the remainder/quotient right shifter.

Parameters:
- WIDTH, 17, datapath width of the controlled shifter; a request amount is clamped to this value.
- AMT_W, 5, width of the amount and step-count fields; must satisfy 2^AMT_W > WIDTH.
- MAX_STEP, 7, largest shift issued in a single cycle; legal range 1..7 to fit the 3-bit shift_pos.

Ports:
- clk  input  1  system clock, rising edge.
- rst_b  input  1  synchronous reset, active-high.
- start  input  1  request strobe; sampled only in IDLE.
- amount  input  AMT_W  total right shift requested; sampled with start.
- abort  input  1  cancel the operation in progress.
- sh_load  output  1  to shifter load.
- sh_enable  output  1  to shifter enable.
- sh_shift_pos  output  3  to shifter shift_pos.
- busy  output  1  high in LOAD and SHIFT.
- done  output  1  one-cycle completion pulse.
- aborted  output  1  one-cycle pulse when an abort is accepted.
- step_count  output  AMT_W  number of enable cycles issued in the current or last operation.

Behaviour:
- Clock and reset: one clock (clk). rst_b is synchronous, active-high. All state is updated on the rising edge of clk.
- Reset values: state=IDLE; remaining=0; step_count=0. sh_load, sh_enable, sh_shift_pos, busy, done and aborted are all 0.
- All outputs are registered or decoded from state only (Moore). No input reaches an output combinationally.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - start=1 sets remaining to min(amount, WIDTH) and clears step_count.
  - Next state is LOAD.
- LOAD:
  - sh_load=1 for exactly one cycle; sh_enable=0.
  - Next state is DONE if remaining==0, else SHIFT.
- SHIFT:
  - sh_enable=1 and sh_shift_pos=min(remaining, MAX_STEP).
  - Each cycle: remaining decreases by that step, step_count increments.
  - Next state is DONE when the new remaining is 0, else stay in SHIFT.
- DONE: done=1 for one cycle, then IDLE.
- Output exclusivity: sh_load and sh_enable are never both 1. sh_shift_pos=0 whenever sh_enable=0.
- Latency: with start sampled at edge t and k = ceil(min(N, WIDTH)/MAX_STEP):
  - sh_load high in cycle t+1.
  - sh_enable high in cycles t+2 .. t+1+k.
  - done high in cycle t+2+k.
  - N=0 gives done at t+2, with no enable cycles.
- Clamping: amount > WIDTH is treated as WIDTH. No error is flagged.
- start outside IDLE (LOAD, SHIFT, DONE) is ignored. The request is not queued.
- abort:
  - In LOAD or SHIFT: next state is IDLE, aborted=1 for one cycle, done is not asserted, step_count holds its value.
  - In IDLE or DONE: ignored.
  - abort and start together in IDLE: start wins.
- Reset mid-operation: immediate return to the reset values at the next edge. No done or aborted pulse.

Decomposition:
- Shared package (divider_pkg):
  - State enum typedef {IDLE, LOAD, SHIFT, DONE}.
  - Constant SHIFT_POS_W=3.
  - Constant MAX_STEP_LIMIT=7, checked against MAX_STEP by an elaboration-time assertion.
- Single module; no sub-module is needed. The min(remaining, MAX_STEP) step calculation is inline combinational logic.

Test Plan:
- Reset, then start with amount=0 -> sh_load in cycle 1, done in cycle 2, no sh_enable, step_count=0.
- amount=5 -> one enable cycle with shift_pos=5, done in cycle 3, step_count=1.
- amount=17 -> enables with shift_pos 7, 7, 3, done in cycle 5, step_count=3. Bench also instantiates the shifter: in=17'h1FFFF ends at 0.
- amount=20 -> clamped to 17; same sequence as amount=17.
- amount=17, abort during the second enable cycle -> aborted pulse, IDLE next cycle, no done, step_count=2. A subsequent start with amount=3 completes normally.
- start pulsed again during SHIFT -> ignored, original sequence unchanged. rst_b asserted mid-SHIFT -> all outputs 0 next cycle.
